// File: rtl/sec_ded_pkg.sv
// Shared definitions for the 8-bit SEC-DED code: widths, codeword position map
// and the Hamming check-bit function used by both encoder and checker.
package sec_ded_pkg;

  localparam int DATA_W  = 8;
  localparam int CHECK_W = 5;
  localparam int SYN_W   = 4;

  // Codeword position (1..12) of each data bit d0..d7; p1/p2/p4/p8 sit at 1/2/4/8.
  localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              single;
    logic              double_err;
    logic [SYN_W-1:0]  syndrome;
  } result_t;

  // Check bit pN covers every data bit whose position has bit N set.
  function automatic logic [SYN_W-1:0] calc_check(input logic [DATA_W-1:0] d);
    logic [SYN_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int b = 0; b < SYN_W; b++) begin
        c[b] = c[b] ^ (d[i] & DATA_POS[i][b]);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sec_ded_syndrome.sv
// Combinational syndrome and overall-parity generator for one stored word.
module sec_ded_syndrome
  import sec_ded_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [CHECK_W-1:0] check,
  output logic [SYN_W-1:0]   syndrome,
  output logic               pe
);

  assign syndrome = calc_check(data) ^ check[SYN_W-1:0];
  assign pe       = ^{data, check};

endmodule

// File: rtl/sec_ded_checker.sv
// Two-stage SEC-DED checker: stage 1 registers syndrome/parity, stage 2 classifies
// and corrects; saturating counters track accepted single and double errors.
module sec_ded_checker
  import sec_ded_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CHECK_W-1:0] in_check,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_single,
  output logic               out_double,
  output logic [SYN_W-1:0]   out_syndrome,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   single_cnt,
  output logic [CNT_W-1:0]   double_cnt
);

  // Handshake: a word moves on valid & ready; a stage loads when it is empty or
  // its consumer takes the current word, so stalled registers hold unchanged.
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [SYN_W-1:0]  s1_syn;
  logic              s1_pe;
  logic              s2_adv;
  logic              s1_adv;
  logic              out_fire;

  logic [SYN_W-1:0]  syn_c;
  logic              pe_c;
  result_t           res_c;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = out_valid & out_ready;

  sec_ded_syndrome u_syndrome (
    .data     (in_data),
    .check    (in_check),
    .syndrome (syn_c),
    .pe       (pe_c)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_pe    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_syn  <= syn_c;
        s1_pe   <= pe_c;
      end
    end
  end

  // Zero syndrome with odd parity means only P flipped; nonzero syndrome with
  // even parity, or one beyond position 12, cannot be a single flip.
  always_comb begin
    res_c            = '0;
    res_c.data       = s1_data;
    res_c.syndrome   = s1_syn;
    if (s1_syn == '0) begin
      res_c.single = s1_pe;
    end else if (!s1_pe || s1_syn > 4'd12) begin
      res_c.double_err = 1'b1;
    end else begin
      res_c.single = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
        if (s1_syn == DATA_POS[i]) res_c.data[i] = ~s1_data[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_single   <= 1'b0;
      out_double   <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= res_c.data;
        out_single   <= res_c.single;
        out_double   <= res_c.double_err;
        out_syndrome <= res_c.syndrome;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (clr_cnt) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (out_fire) begin
      if (out_single && single_cnt != '1) single_cnt <= single_cnt + CNT_W'(1);
      if (out_double && double_cnt != '1) double_cnt <= double_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sec_ded_checker.sv
// Directed bench for sec_ded_checker with 2-bit counters so saturation is reachable.
module tb_sec_ded_checker;

  logic       CLK;
  logic       RSTn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_check;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_single;
  logic       out_double;
  logic [3:0] out_syndrome;
  logic       clr_cnt;
  logic [1:0] single_cnt;
  logic [1:0] double_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] wd[4];
  logic [4:0] wc[4];
  int         idx;
  int         got;
  logic       acc;

  sec_ded_checker #(.CNT_W(2)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_check     (in_check),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_single   (out_single),
    .out_double   (out_double),
    .out_syndrome (out_syndrome),
    .clr_cnt      (clr_cnt),
    .single_cnt   (single_cnt),
    .double_cnt   (double_cnt)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one word with out_ready = 1, check the result and the counters after its transfer.
  task automatic send_chk(input string tag, input logic [7:0] d, input logic [4:0] c,
                          input logic [7:0] ed, input logic es, input logic edb,
                          input logic [3:0] esyn, input logic clr,
                          input logic [1:0] esc, input logic [1:0] edc);
    int n;
    @(negedge CLK);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_check  = c;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1'b1));
    @(negedge CLK);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(1));
    chk({tag, "_valid"},   32'(out_valid),    32'(1'b1));
    chk({tag, "_data"},    32'(out_data),     32'(ed));
    chk({tag, "_single"},  32'(out_single),   32'(es));
    chk({tag, "_double"},  32'(out_double),   32'(edb));
    chk({tag, "_syn"},     32'(out_syndrome), 32'(esyn));
    clr_cnt = clr;
    @(negedge CLK);
    clr_cnt = 1'b0;
    chk({tag, "_single_cnt"}, 32'(single_cnt), 32'(esc));
    chk({tag, "_double_cnt"}, 32'(double_cnt), 32'(edc));
    chk({tag, "_drained"},    32'(out_valid),  32'(1'b0));
  endtask

  initial begin
    RSTn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_check  = '0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_out_valid",  32'(out_valid),    32'(1'b0));
    chk("rst_out_data",   32'(out_data),     32'(8'h00));
    chk("rst_out_single", 32'(out_single),   32'(1'b0));
    chk("rst_out_double", 32'(out_double),   32'(1'b0));
    chk("rst_syndrome",   32'(out_syndrome), 32'(4'h0));
    chk("rst_single_cnt", 32'(single_cnt),   32'(2'd0));
    chk("rst_double_cnt", 32'(double_cnt),   32'(2'd0));
    RSTn = 1'b1;

    // clean, correctable and uncorrectable words
    send_chk("clean",   8'hA5, 5'h03, 8'hA5, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0);
    send_chk("d3_flip", 8'hAD, 5'h03, 8'hA5, 1'b1, 1'b0, 4'h7, 1'b0, 2'd1, 2'd0);
    send_chk("p_flip",  8'hA5, 5'h13, 8'hA5, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 2'd0);
    send_chk("p1_flip", 8'hA5, 5'h02, 8'hA5, 1'b1, 1'b0, 4'h1, 1'b0, 2'd3, 2'd0);
    send_chk("double",  8'hA6, 5'h03, 8'hA6, 1'b0, 1'b1, 4'h6, 1'b0, 2'd3, 2'd1);
    send_chk("triple",  8'h24, 5'h01, 8'h24, 1'b0, 1'b1, 4'hD, 1'b0, 2'd3, 2'd2);
    send_chk("d7_flip", 8'h25, 5'h03, 8'hA5, 1'b1, 1'b0, 4'hC, 1'b0, 2'd3, 2'd2);

    // backpressure: four clean words, out_ready low for three cycles
    wd = '{8'hFF, 8'h00, 8'h01, 8'h80};
    wc = '{5'h03, 5'h00, 5'h13, 5'h1C};
    exp_q.delete();
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge CLK);
      out_ready = !(cyc >= 1 && cyc <= 3);
      #1;
      if (cyc == 2 || cyc == 3) begin
        chk("bp_in_ready_low", 32'(in_ready),  32'(1'b0));
        chk("bp_hold_valid",   32'(out_valid), 32'(1'b1));
        chk("bp_hold_data",    32'(out_data),  32'(8'hFF));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL bp_extra: observed word %0h expected none", out_data);
        end else begin
          chk("bp_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        chk("bp_flags", 32'({out_single, out_double}), 32'(2'b00));
        got++;
      end
      if (idx < 4) begin
        in_valid = 1'b1;
        in_data  = wd[idx];
        in_check = wc[idx];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge CLK);
      if (acc) begin
        exp_q.push_back(wd[idx]);
        idx++;
      end
    end
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_words_out", 32'(got), 32'(4));
    chk("bp_words_in",  32'(idx), 32'(4));
    chk("bp_cnt_single", 32'(single_cnt), 32'(2'd3));
    chk("bp_cnt_double", 32'(double_cnt), 32'(2'd2));

    // fifth single stays saturated, then clear wins over a same-cycle single
    send_chk("sat",   8'hAD, 5'h03, 8'hA5, 1'b1, 1'b0, 4'h7, 1'b0, 2'd3, 2'd2);
    send_chk("clr",   8'hAD, 5'h03, 8'hA5, 1'b1, 1'b0, 4'h7, 1'b1, 2'd0, 2'd0);
    send_chk("dbl2",  8'hA6, 5'h03, 8'hA6, 1'b0, 1'b1, 4'h6, 1'b0, 2'd0, 2'd1);

    // reset with two words in flight
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_check  = 5'h03;
    @(negedge CLK);
    in_data   = 8'h00;
    in_check  = 5'h00;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("mid_valid_before", 32'(out_valid), 32'(1'b1));
    RSTn = 1'b0;
    #1;
    chk("mid_valid_after",  32'(out_valid),  32'(1'b0));
    chk("mid_data",         32'(out_data),   32'(8'h00));
    chk("mid_double_cnt",   32'(double_cnt), 32'(2'd0));
    chk("mid_single_cnt",   32'(single_cnt), 32'(2'd0));
    @(negedge CLK);
    RSTn      = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("mid_discarded", 32'(out_valid), 32'(1'b0));
    end
    chk("mid_cnt_stay", 32'(double_cnt), 32'(2'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
